bit_serial_adder: RTL and testbench

//   Parametrised bit-serial adder: successor to the single-cell full-adder lab block (a,b,c -> x=sum, y=carry).

---
 rtl/bsa_pkg.sv | 10 +
 rtl/bit_serial_adder_fa.sv | 13 +
 rtl/bit_serial_adder.sv | 131 +++++++++++++
 tb/tb_bit_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Single full-adder cell evaluated once per clock by the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x,
  output logic y
);

  assign x = a ^ b ^ c;
  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder with valid/ready handshakes on both sides.
// Optional subtract mode is compiled in with the BSA_SUB_EN macro.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef BSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_x, fa_y;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH-1:0] sh_ext;

`ifdef BSA_SUB_EN
  // Subtraction as A + ~B + 1; c_out then reads as "no borrow".
  assign b_load = sub ? ~b_in : b_in;
  assign c_load = sub ? 1'b1 : c_in;
`else
  assign b_load = b_in;
  assign c_load = c_in;
`endif

  full_adder_cell u_fa (
    .a (a_q[0]),
    .b (b_q[0]),
    .c (carry_q),
    .x (fa_x),
    .y (fa_y)
  );

  // The partial sum fills from the MSB; on the last bit the full word is complete.
  assign sh_ext = {fa_x, sh_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sh_d    = sh_ext[WIDTH-1:1];
        carry_d = fa_y;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = sh_ext;
          cout_d  = fa_y;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign c_out     = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: WIDTH=8 directed/random ops and a WIDTH=3 exhaustive sweep.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       iv8, ir8, ov8, ordy8, c8, co8, busy8;
  logic [7:0] a8, b8, s8;
  logic       iv3, ir3, ov3, ordy3, c3, co3, busy3;
  logic [2:0] a3, b3, s3;
`ifdef BSA_SUB_EN
  logic       sub8, sub3;
`endif

  int checks   = 0;
  int failures = 0;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a_in      (a8),
    .b_in      (b8),
    .c_in      (c8),
`ifdef BSA_SUB_EN
    .sub       (sub8),
`endif
    .out_valid (ov8),
    .out_ready (ordy8),
    .sum       (s8),
    .c_out     (co8),
    .busy      (busy8)
  );

  bit_serial_adder #(.WIDTH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv3),
    .in_ready  (ir3),
    .a_in      (a3),
    .b_in      (b3),
    .c_in      (c3),
`ifdef BSA_SUB_EN
    .sub       (sub3),
`endif
    .out_valid (ov3),
    .out_ready (ordy3),
    .sum       (s3),
    .c_out     (co3),
    .busy      (busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; the expected result is plain integer arithmetic.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb,
                     input int hold, input bit poke, input string tag);
    logic [8:0] exp;
    logic [7:0] nb;
    logic [7:0] hs;
    logic       hc;
    int         lat;
    nb  = ~b;
    exp = sb ? ({1'b0, a} + {1'b0, nb} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
    a8 = a; b8 = b; c8 = c;
`ifdef BSA_SUB_EN
    sub8 = sb;
`endif
    ordy8 = (hold == 0);
    iv8   = 1'b1;
    lat = 0;
    while (!ir8 && lat < 50) begin @(negedge clk); lat++; end
    chk({tag, "_accept"}, 32'(ir8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 50) begin
      if (poke && lat == 2) begin
        iv8 = 1'b1;
        a8  = ~a;
        chk({tag, "_rdy_run"}, 32'(ir8), 32'd0);
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_result"}, 32'({co8, s8}), 32'(exp));
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    if (hold > 0) begin
      hs = s8;
      hc = co8;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold"}, 32'({ov8, hc, hs}), 32'({1'b1, exp}));
        if (poke) chk({tag, "_rdy_done"}, 32'(ir8), 32'd0);
      end
      ordy8 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    chk({tag, "_vld_drop"}, 32'(ov8), 32'd0);
    chk({tag, "_retain"}, 32'({co8, s8}), 32'(exp));
    if (poke) begin
      repeat (3) @(negedge clk);
      chk({tag, "_not_queued"}, 32'(busy8), 32'd0);
    end
  endtask

  initial begin
    int         lat;
    logic [3:0] exp3;

    rst_n = 1'b0;
    iv8 = 1'b1; ordy8 = 1'b1; a8 = 8'h55; b8 = 8'h66; c8 = 1'b1;
    iv3 = 1'b1; ordy3 = 1'b1; a3 = 3'd5;  b3 = 3'd6;  c3 = 1'b1;
`ifdef BSA_SUB_EN
    sub8 = 1'b0; sub3 = 1'b0;
`endif
    #2;
    chk("rst_outs8", 32'({s8, co8, ov8, busy8, ir8}), 32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
    chk("rst_outs3", 32'({s3, co3, ov3, busy3, ir3}), 32'({3'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
    repeat (3) @(negedge clk);
    chk("rst_ignore_valid", 32'({busy8, busy3}), 32'd0);
    rst_n = 1'b1;
    iv8 = 1'b0;
    iv3 = 1'b0;
    @(negedge clk);

    op8(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, "zero");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, "ripple");
    op8(8'hA5, 8'h5A, 1'b1, 1'b0, 0, 1'b0, "a5_5a_c1");
    op8(8'h5C, 8'h27, 1'b1, 1'b0, 5, 1'b1, "stall");

    // Reset during the third RUN cycle discards the operation.
    op8(8'h33, 8'h11, 1'b0, 1'b0, 0, 1'b0, "pre_rst");
    a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b1; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst", 32'({s8, co8, ov8, busy8, ir8}), 32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    iv8 = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_idle", 32'(busy8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    iv8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_partial", 32'({ov8, busy8}), 32'd0);
    op8(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0, "after_rst");

    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, (i % 5 == 0) ? 2 : 0, 1'b0, "rand");
    end

`ifdef BSA_SUB_EN
    op8(8'h10, 8'h03, 1'b0, 1'b1, 0, 1'b0, "sub_nb");
    op8(8'h03, 8'h10, 1'b1, 1'b1, 0, 1'b0, "sub_b");
    op8(8'h42, 8'h17, 1'b1, 1'b0, 0, 1'b0, "sub0_add");
`endif

    // WIDTH=3 exhaustive back-to-back sweep.
    ordy3 = 1'b1;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp3 = 4'(a) + 4'(b) + 4'(c);
          a3 = 3'(a); b3 = 3'(b); c3 = 1'(c);
          iv3 = 1'b1;
          lat = 0;
          while (!ir3 && lat < 20) begin @(negedge clk); lat++; end
          @(posedge clk);
          @(negedge clk);
          iv3 = 1'b0;
          lat = 0;
          while (!ov3 && lat < 20) begin @(negedge clk); lat++; end
          chk("w3_latency", 32'(lat), 32'd3);
          chk("w3_result", 32'({co3, s3}), 32'(exp3));
        end
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("w3_idle", 32'({ov3, busy3}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
